rvx_core_writeback_arbiter: RTL

Drives the integer file's single write port. It merges same-cycle pipeline writebacks with results from long-latency execution units (divider, CSR/memory side units), which complete out of order. A per-register busy scoreboard lets the stage-1 logic stall on RAW/WAW hazards against outstanding long-latency destinations. It sits between the stage-2 writeback mux and the integer file.

---
 rtl/rvx_core_writeback_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/rvx_core_writeback_arbiter.sv
// Integer-file write port arbiter: pipeline writebacks take priority over a one-entry
// long-latency result buffer; a busy scoreboard flags stage-1 hazards on outstanding rd.
module rvx_core_writeback_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic        pipe_write_request_s2,
    input  logic [4:0]  pipe_rd_address_s2,
    input  logic [31:0] pipe_rd_data_s2,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rd_address,
    input  logic        unit_result_valid,
    output logic        unit_result_ready,
    input  logic [4:0]  unit_rd_address,
    input  logic [31:0] unit_rd_data,
    input  logic [4:0]  rs1_address_s1,
    input  logic [4:0]  rs2_address_s1,
    input  logic [4:0]  rd_address_s1,
    output logic        hazard_s1,
    output logic        write_request_s2,
    output logic [4:0]  rd_address_s2,
    output logic [31:0] rd_data_s2,
    output logic [2:0]  pending_count
);

    // Bit 0 is held at zero so x0 indexes never see a busy register.
    logic [31:0] busy_q, busy_d;
    logic [2:0]  pending_q, pending_d;
    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic en, pipe_win, buf_drain, issue_fire, result_fire;

    always_comb begin
        en          = clock_enable & ~reset;
        pipe_win    = en & pipe_write_request_s2;
        buf_drain   = en & buf_valid_q & ~pipe_write_request_s2;
        issue_ready = en & (pending_q < 3'(MAX_PENDING))
                         & ((issue_rd_address == 5'd0) | ~busy_q[issue_rd_address]);
        unit_result_ready = en & (~buf_valid_q | buf_drain);
        issue_fire  = issue_valid & issue_ready;
        result_fire = unit_result_valid & unit_result_ready;

        write_request_s2 = pipe_win | (buf_drain & (buf_addr_q != 5'd0));
        rd_address_s2    = pipe_win ? pipe_rd_address_s2 : buf_addr_q;
        rd_data_s2       = pipe_win ? pipe_rd_data_s2    : buf_data_q;

        hazard_s1 = ~reset & (busy_q[rs1_address_s1] | busy_q[rs2_address_s1]
                            | busy_q[rd_address_s1]);
        pending_count = pending_q;
    end

    always_comb begin
        busy_d = busy_q;
        if (buf_drain)
            busy_d[buf_addr_q] = 1'b0;
        if (issue_fire)
            busy_d[issue_rd_address] = 1'b1;
        busy_d[0] = 1'b0;

        pending_d = pending_q + {2'b00, issue_fire} - {2'b00, buf_drain};

        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (result_fire) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = unit_rd_address;
            buf_data_d  = unit_rd_data;
        end else if (buf_drain) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q      <= '0;
            pending_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (clock_enable) begin
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule
